// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks a flat instruction memory and
// feeds a small prefetch FIFO, with redirect flush and end-of-program stop.
module instr_fetch_ctrl #(
    parameter int          DEPTH      = 2,
    parameter int          IMEM_WORDS = 32,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        done_o,
    output logic [15:0] fetch_cnt_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [32:0] LIMIT = 33'(IMEM_WORDS * 4);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        FETCH,
        DONE
    } state_t;

    state_t        state;
    logic [31:0]   fpc;
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [15:0]   fetch_cnt;

    logic pop;
    logic push;
    logic in_range;
    logic at_end;

    assign imem_addr_o = fpc;
    assign fetch_cnt_o = fetch_cnt;

    assign valid_o = (count != '0);
    assign instr_o = valid_o ? instr_q[head] : 32'h0;
    assign pc_o    = valid_o ? pc_q[head] : 32'h0;
    assign done_o  = (state == DONE) && (count == '0);

    assign pop      = valid_o && ready_i;
    assign in_range = ({1'b0, fpc} < LIMIT);
    // End of program is judged on the memory alone, independent of FIFO room.
    assign at_end   = !in_range || (imem_instr_i == 32'h0);

    assign push = (state == FETCH) && !redirect_i && !at_end
                  && ((count < FULL) || pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= FETCH;
            fpc       <= RESET_PC & ~32'h3;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            fetch_cnt <= '0;
        end else if (redirect_i) begin
            state <= FETCH;
            fpc   <= redirect_pc_i & ~32'h3;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc_q[tail]    <= fpc;
                instr_q[tail] <= imem_instr_i;
                tail          <= tail + 1'b1;
                fpc           <= fpc + 32'd4;
                if (fetch_cnt != 16'hFFFF) begin
                    fetch_cnt <= fetch_cnt + 16'd1;
                end
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (state == FETCH && at_end) begin
                state <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: cycle table for backpressure/redirect/reset,
// plus scoreboarded streaming, redirect and end-of-memory sequences.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        done;
    logic [15:0] fetch_cnt;

    logic [31:0] mem [32];

    always #5 clk = ~clk;

    // Addresses past the memory return a nonzero word so that only the
    // range check can stop fetching there.
    always_comb begin
        imem_instr = 32'hDEAD_BEEF;
        if (imem_addr < 32'd128) imem_instr = mem[imem_addr[6:2]];
    end

    instr_fetch_ctrl #(
        .DEPTH(2),
        .IMEM_WORDS(32),
        .RESET_PC(32'h0)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .imem_addr_o(imem_addr),
        .imem_instr_i(imem_instr),
        .redirect_i(redirect),
        .redirect_pc_i(redirect_pc),
        .ready_i(ready),
        .valid_o(valid),
        .instr_o(instr),
        .pc_o(pc),
        .done_o(done),
        .fetch_cnt_o(fetch_cnt)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [31:0] ea;
        logic        ed;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t v(
        input logic rs, input logic rd, input logic [31:0] rpc,
        input logic rdy, input logic ev, input logic [31:0] ei,
        input logic [31:0] ep, input logic [31:0] ea,
        input logic ed, input logic [15:0] ec);
        vec_t r;
        r.rst = rs; r.rd = rd; r.rpc = rpc; r.rdy = rdy;
        r.ev = ev; r.ei = ei; r.ep = ep; r.ea = ea;
        r.ed = ed; r.ec = ec;
        return r;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t sbq[$];

    task automatic expect_ent(input logic [31:0] p, input logic [31:0] i);
        ent_t e;
        e.pc = p;
        e.instr = i;
        sbq.push_back(e);
    endtask

    task automatic mon_cycle();
        ent_t e;
        @(negedge clk);
        if (valid && ready) begin
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL pop_unexpected: got pc %h instr %h, none due",
                         pc, instr);
            end else begin
                e = sbq.pop_front();
                check("pop_pc", pc, e.pc);
                check("pop_instr", instr, e.instr);
            end
        end
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        ready = 1'b0;
        sbq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ready = rdy;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0] = 32'h11; mem[1] = 32'h22;
        mem[2] = 32'h33; mem[3] = 32'h44;
        mem[4] = 32'h0;
        for (int i = 5; i < 32; i++) mem[i] = 32'h500 + i;

        //           rst rd rpc  rdy  v  instr  pc    addr  done cnt
        tbl[0]  = v(0, 0, 0,    0,   0, 0,     0,    0,    0,   0);
        tbl[1]  = v(0, 0, 0,    0,   1, 'h11,  0,    4,    0,   1);
        tbl[2]  = v(0, 0, 0,    0,   1, 'h11,  0,    8,    0,   2);
        tbl[3]  = v(0, 0, 0,    0,   1, 'h11,  0,    8,    0,   2);
        tbl[4]  = v(0, 0, 0,    0,   1, 'h11,  0,    8,    0,   2);
        tbl[5]  = v(0, 0, 0,    1,   1, 'h11,  0,    8,    0,   2);
        tbl[6]  = v(0, 0, 0,    1,   1, 'h22,  4,    'hC,  0,   3);
        tbl[7]  = v(0, 0, 0,    1,   1, 'h33,  8,    'h10, 0,   4);
        tbl[8]  = v(0, 0, 0,    1,   1, 'h44,  'hC,  'h10, 0,   4);
        tbl[9]  = v(0, 1, 5,    0,   0, 0,     0,    'h10, 1,   4);
        tbl[10] = v(0, 0, 0,    1,   0, 0,     0,    4,    0,   4);
        tbl[11] = v(0, 0, 0,    1,   1, 'h22,  4,    8,    0,   5);
        tbl[12] = v(0, 1, 0,    1,   1, 'h33,  8,    'hC,  0,   6);
        tbl[13] = v(0, 0, 0,    0,   0, 0,     0,    0,    0,   6);
        tbl[14] = v(0, 0, 0,    0,   1, 'h11,  0,    4,    0,   7);
        tbl[15] = v(0, 0, 0,    1,   1, 'h11,  0,    8,    0,   8);
        tbl[16] = v(0, 0, 0,    0,   1, 'h22,  4,    'hC,  0,   9);
        tbl[17] = v(0, 1, 8,    0,   1, 'h22,  4,    'hC,  0,   9);
        tbl[18] = v(0, 0, 0,    0,   0, 0,     0,    8,    0,   9);
        tbl[19] = v(0, 0, 0,    0,   1, 'h33,  8,    'hC,  0,   10);
        tbl[20] = v(0, 0, 0,    0,   1, 'h33,  8,    'h10, 0,   11);
        tbl[21] = v(1, 1, 'h40, 1,   1, 'h33,  8,    'h10, 0,   11);
        tbl[22] = v(0, 0, 0,    1,   0, 0,     0,    0,    0,   0);
        tbl[23] = v(0, 0, 0,    1,   1, 'h11,  0,    4,    0,   1);

        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        ready = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check($sformatf("t%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
            check($sformatf("t%0d_instr", i), instr, tbl[i].ei);
            check($sformatf("t%0d_pc", i), pc, tbl[i].ep);
            check($sformatf("t%0d_addr", i), imem_addr, tbl[i].ea);
            check($sformatf("t%0d_done", i), 32'(done), 32'(tbl[i].ed));
            check($sformatf("t%0d_cnt", i), 32'(fetch_cnt), 32'(tbl[i].ec));
            rst = tbl[i].rst;
            redirect = tbl[i].rd;
            redirect_pc = tbl[i].rpc;
            ready = tbl[i].rdy;
        end

        // Streaming four words to a zero terminator.
        do_reset(1'b1);
        expect_ent(32'h0, 32'h11);
        expect_ent(32'h4, 32'h22);
        expect_ent(32'h8, 32'h33);
        expect_ent(32'hC, 32'h44);
        for (int c = 0; c < 40; c++) begin
            mon_cycle();
            if (done && sbq.size() == 0) break;
        end
        check("s1_done", 32'(done), 32'd1);
        check("s1_left", 32'(sbq.size()), 32'd0);
        check("s1_cnt", 32'(fetch_cnt), 32'd4);
        check("s1_addr", imem_addr, 32'h10);

        for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + i;

        // Redirect to an unaligned target while streaming.
        do_reset(1'b1);
        expect_ent(32'h0, 32'h1000);
        expect_ent(32'h4, 32'h1001);
        for (int c = 0; c < 10; c++) begin
            mon_cycle();
            if (imem_addr == 32'h8) break;
        end
        check("s2_at8", imem_addr, 32'h8);
        redirect = 1'b1;
        redirect_pc = 32'h13;
        @(negedge clk);
        check("s2_flush_valid", 32'(valid), 32'd0);
        check("s2_flush_addr", imem_addr, 32'h10);
        redirect = 1'b0;
        redirect_pc = 32'h0;
        expect_ent(32'h10, 32'h1004);
        mon_cycle();
        check("s2_left", 32'(sbq.size()), 32'd0);

        // Whole memory nonzero: fetch must stop at the end, not wrap.
        do_reset(1'b1);
        for (int i = 0; i < 32; i++) expect_ent(32'(i * 4), 32'h1000 + i);
        for (int c = 0; c < 100; c++) begin
            mon_cycle();
            if (done && sbq.size() == 0) break;
        end
        repeat (3) mon_cycle();
        check("s3_done", 32'(done), 32'd1);
        check("s3_left", 32'(sbq.size()), 32'd0);
        check("s3_addr", imem_addr, 32'd128);
        check("s3_cnt", 32'(fetch_cnt), 32'd32);
        redirect = 1'b1;
        redirect_pc = 32'h0;
        @(negedge clk);
        check("s3_rd_done", 32'(done), 32'd0);
        check("s3_rd_addr", imem_addr, 32'h0);
        check("s3_rd_valid", 32'(valid), 32'd0);
        redirect = 1'b0;
        expect_ent(32'h0, 32'h1000);
        mon_cycle();
        check("s3_restart", 32'(sbq.size()), 32'd0);
        check("s3_cnt_kept", 32'(fetch_cnt), 32'd33);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
